// File: rtl/sys_memory_banked_if.sv
// Host/display bus for sys_memory_banked: write port, read port, commit strobe and status.
interface sys_memory_banked_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 7
);
  logic              WESM;
  logic [ADDR_W-1:0] WAddr;
  logic [DATA_W-1:0] WDataIn;
  logic              RESM;
  logic [ADDR_W-1:0] AddrSM;
  logic              FrameDone;
  logic [DATA_W-1:0] WData;
  logic              RValid;
  logic              AddrErr;
  logic              SwapPending;
  logic [2:0]        RdBank;
  logic [2:0]        WrBank;
  logic [ADDR_W:0]   WrCount;

  modport master (
    output WESM, WAddr, WDataIn, RESM, AddrSM, FrameDone,
    input  WData, RValid, AddrErr, SwapPending, RdBank, WrBank, WrCount
  );

  modport slave (
    input  WESM, WAddr, WDataIn, RESM, AddrSM, FrameDone,
    output WData, RValid, AddrErr, SwapPending, RdBank, WrBank, WrCount
  );
endinterface

// File: rtl/sys_memory_banked.sv
// Ring of NUM_BANKS pixel frame banks: host fills WrBank, display reads RdBank, commits deferred past read bursts.
module sys_memory_banked #(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned DEPTH     = 100,
  parameter int unsigned NUM_BANKS = 3
`ifdef SYSMEM_INIT_EN
  ,
  parameter string       INIT_FILE = "sysmem_init.hex"
`endif
) (
  input  logic                Clock,
  input  logic                Reset,
  sys_memory_banked_if.slave  bus
);

  localparam int unsigned     MEM_WORDS = NUM_BANKS * DEPTH;
  localparam int unsigned     IDX_W     = $clog2(MEM_WORDS);
  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [2:0]      LAST_BANK = 3'(NUM_BANKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    SWAP
  } state_t;

  // All banks share one flat array; bank b occupies words b*DEPTH .. b*DEPTH+DEPTH-1.
  logic [DATA_W-1:0] mem [MEM_WORDS];

  state_t            state_q, state_d;
  logic [2:0]        rd_bank_q, rd_bank_d;
  logic [2:0]        wr_bank_q, wr_bank_d;
  logic [ADDR_W:0]   wr_count_q, wr_count_d;
  logic              swap_pend_q, swap_pend_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rvalid_q, rvalid_d;
  logic              addr_err_q, addr_err_d;

  logic              wr_in_range, rd_in_range;
  logic              wr_ok, rd_ok;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  assign wr_in_range = ({1'b0, bus.WAddr}  < DEPTH_C);
  assign rd_in_range = ({1'b0, bus.AddrSM} < DEPTH_C);
  assign wr_ok       = bus.WESM && wr_in_range;
  assign rd_ok       = bus.RESM && rd_in_range;
  assign wr_idx      = IDX_W'(wr_bank_q) * IDX_W'(DEPTH) + IDX_W'(bus.WAddr);
  assign rd_idx      = IDX_W'(rd_bank_q) * IDX_W'(DEPTH) + IDX_W'(bus.AddrSM);

  always_ff @(posedge Clock) begin
    if (wr_ok) begin
      mem[wr_idx] <= bus.WDataIn;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    wr_bank_d   = wr_bank_q;
    swap_pend_d = swap_pend_q;
    wr_count_d  = (wr_ok && (wr_count_q < DEPTH_C)) ? wr_count_q + CNT_ONE : wr_count_q;

    unique case (state_q)
      IDLE: begin
        if (bus.FrameDone) begin
          state_d     = PEND;
          swap_pend_d = 1'b1;
        end
      end
      PEND: begin
        if (!bus.RESM) begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        // A write landing in this cycle still targets the old bank and is not counted.
        rd_bank_d   = wr_bank_q;
        wr_bank_d   = (wr_bank_q == LAST_BANK) ? '0 : wr_bank_q + 3'd1;
        wr_count_d  = '0;
        swap_pend_d = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rvalid_d   = bus.RESM;
    addr_err_d = (bus.WESM && !wr_in_range) || (bus.RESM && !rd_in_range);
    wdata_d    = wdata_q;
    if (rd_ok) begin
      wdata_d = mem[rd_idx];
    end else if (bus.RESM) begin
      wdata_d = '0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      rd_bank_q   <= 3'd0;
      wr_bank_q   <= 3'd1;
      wr_count_q  <= '0;
      swap_pend_q <= 1'b0;
      wdata_q     <= '0;
      rvalid_q    <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      wr_bank_q   <= wr_bank_d;
      wr_count_q  <= wr_count_d;
      swap_pend_q <= swap_pend_d;
      wdata_q     <= wdata_d;
      rvalid_q    <= rvalid_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign bus.WData       = wdata_q;
  assign bus.RValid      = rvalid_q;
  assign bus.AddrErr     = addr_err_q;
  assign bus.SwapPending = swap_pend_q;
  assign bus.RdBank      = rd_bank_q;
  assign bus.WrBank      = wr_bank_q;
  assign bus.WrCount     = wr_count_q;

endmodule

// File: tb/tb_sys_memory_banked.sv
// Randomized and directed bench for sys_memory_banked against a bank-ring reference model.
module tb_sys_memory_banked;

  localparam int DW = 24;
  localparam int AW = 7;
  localparam int DEP = 100;
  localparam int NB = 3;

  logic clk = 1'b0;
  logic rst;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sys_memory_banked_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  sys_memory_banked #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .DEPTH    (DEP),
    .NUM_BANKS(NB)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus.slave)
  );

  // Reference model: banks as a 2-D array, commit as "pending" then "armed" then applied.
  logic [DW-1:0] m_mem   [NB][DEP];
  bit            m_known [NB][DEP];
  int            m_rd = 0, m_wr = 1, m_cnt = 0;
  bit            m_pend = 0, m_armed = 0, m_rvalid = 0, m_err = 0, m_wknown = 1;
  logic [DW-1:0] m_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rd = 0; m_wr = 1; m_cnt = 0; m_pend = 0; m_armed = 0;
      m_rvalid = 0; m_err = 0; m_wdata = '0; m_wknown = 1;
    end else begin
      bit wok;
      wok      = bus.WESM && (int'(bus.WAddr) < DEP);
      m_err    = (bus.WESM && int'(bus.WAddr) >= DEP) || (bus.RESM && int'(bus.AddrSM) >= DEP);
      m_rvalid = bus.RESM;
      if (bus.RESM) begin
        if (int'(bus.AddrSM) < DEP) begin
          m_wdata  = m_mem[m_rd][bus.AddrSM];
          m_wknown = m_known[m_rd][bus.AddrSM];
        end else begin
          m_wdata  = '0;
          m_wknown = 1;
        end
      end
      if (wok) begin
        m_mem[m_wr][bus.WAddr]   = bus.WDataIn;
        m_known[m_wr][bus.WAddr] = 1;
      end
      if (m_armed) begin
        m_rd = m_wr; m_wr = (m_wr + 1) % NB; m_cnt = 0; m_pend = 0; m_armed = 0;
      end else begin
        if (wok && m_cnt < DEP) m_cnt++;
        if (m_pend && !bus.RESM) m_armed = 1;
        else if (!m_pend && bus.FrameDone) m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("RValid", 32'(bus.RValid), 32'(m_rvalid));
      if (m_wknown) chk("WData", 32'(bus.WData), 32'(m_wdata));
      chk("AddrErr", 32'(bus.AddrErr), 32'(m_err));
      chk("SwapPending", 32'(bus.SwapPending), 32'(m_pend));
      chk("RdBank", 32'(bus.RdBank), 32'(m_rd));
      chk("WrBank", 32'(bus.WrBank), 32'(m_wr));
      chk("WrCount", 32'(bus.WrCount), 32'(m_cnt));
      chk("BankDistinct", 32'(bus.RdBank == bus.WrBank), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.WESM = 0; bus.WAddr = '0; bus.WDataIn = '0;
    bus.RESM = 0; bus.AddrSM = '0; bus.FrameDone = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_WData"},       32'(bus.WData), 32'd0);
    chk({tag, "_RValid"},      32'(bus.RValid), 32'd0);
    chk({tag, "_AddrErr"},     32'(bus.AddrErr), 32'd0);
    chk({tag, "_SwapPending"}, 32'(bus.SwapPending), 32'd0);
    chk({tag, "_RdBank"},      32'(bus.RdBank), 32'd0);
    chk({tag, "_WrBank"},      32'(bus.WrBank), 32'd1);
    chk({tag, "_WrCount"},     32'(bus.WrCount), 32'd0);
  endtask

  initial begin
    logic [AW:0] cnt_before;
    rst = 1'b1;
    idle_inputs();
    repeat (2) tick();
    chk_reset_vals("rst");
    rst = 1'b0;
    tick();

    // Write 0xA5A5A5 at address 5 of bank 1, commit, read it back.
    bus.WESM = 1; bus.WAddr = 7'd5; bus.WDataIn = 24'hA5A5A5;
    tick();
    chk("t1_WrCount", 32'(bus.WrCount), 32'd1);
    bus.WESM = 0; bus.FrameDone = 1;
    tick();
    chk("t1_SwapPending", 32'(bus.SwapPending), 32'd1);
    bus.FrameDone = 0;
    tick();
    chk("t1_RdBank_before", 32'(bus.RdBank), 32'd0);
    tick();
    chk("t1_RdBank", 32'(bus.RdBank), 32'd1);
    chk("t1_WrBank", 32'(bus.WrBank), 32'd2);
    chk("t1_WrCount0", 32'(bus.WrCount), 32'd0);
    bus.RESM = 1; bus.AddrSM = 7'd5;
    tick();
    chk("t1_RValid", 32'(bus.RValid), 32'd1);
    chk("t1_WData", 32'(bus.WData), 32'hA5A5A5);
    bus.RESM = 0;
    tick();
    chk("t1_RValid_off", 32'(bus.RValid), 32'd0);
    chk("t1_WData_hold", 32'(bus.WData), 32'hA5A5A5);

    // Ten-cycle read burst with FrameDone on cycle 2: commit waits for the burst to end.
    for (int c = 1; c <= 10; c++) begin
      bus.RESM = 1; bus.AddrSM = AW'(c);
      bus.WESM = 1; bus.WAddr = AW'(c + 10); bus.WDataIn = DW'($urandom);
      bus.FrameDone = (c == 2);
      tick();
      if (c >= 2) chk("t2_SwapPending", 32'(bus.SwapPending), 32'd1);
      chk("t2_RdBank_hold", 32'(bus.RdBank), 32'd1);
    end
    chk("t2_WrCount", 32'(bus.WrCount), 32'd10);
    idle_inputs();
    tick();
    chk("t2_RdBank_swapcycle", 32'(bus.RdBank), 32'd1);
    tick();
    chk("t2_RdBank", 32'(bus.RdBank), 32'd2);
    chk("t2_WrBank", 32'(bus.WrBank), 32'd0);
    chk("t2_WrCount0", 32'(bus.WrCount), 32'd0);
    chk("t2_SwapPending0", 32'(bus.SwapPending), 32'd0);

    // Third commit wraps the ring.
    bus.FrameDone = 1;
    tick();
    bus.FrameDone = 0;
    repeat (2) tick();
    chk("t3_RdBank", 32'(bus.RdBank), 32'd0);
    chk("t3_WrBank", 32'(bus.WrBank), 32'd1);

    // Out-of-range write and read.
    cnt_before = bus.WrCount;
    bus.WESM = 1; bus.WAddr = 7'd100; bus.WDataIn = 24'hFFFFFF;
    bus.RESM = 1; bus.AddrSM = 7'd127;
    tick();
    chk("t4_AddrErr", 32'(bus.AddrErr), 32'd1);
    chk("t4_RValid", 32'(bus.RValid), 32'd1);
    chk("t4_WData", 32'(bus.WData), 32'd0);
    chk("t4_WrCount", 32'(bus.WrCount), 32'(cnt_before));
    idle_inputs();
    tick();
    chk("t4_AddrErr_pulse", 32'(bus.AddrErr), 32'd0);

    // 120 writes saturate WrCount at DEPTH.
    for (int i = 0; i < 120; i++) begin
      bus.WESM = 1; bus.WAddr = AW'(i % DEP); bus.WDataIn = DW'($urandom);
      tick();
    end
    chk("t5_WrCount_sat", 32'(bus.WrCount), 32'd100);
    idle_inputs();
    bus.FrameDone = 1;
    tick();
    bus.FrameDone = 0;
    repeat (2) tick();

    // Random traffic checked cycle-by-cycle by the model.
    for (int i = 0; i < 600; i++) begin
      bus.WESM    = ($urandom_range(0, 1) == 1);
      bus.WAddr   = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(100, 127)) : AW'($urandom_range(0, 99));
      bus.WDataIn = DW'($urandom);
      if ($urandom_range(0, 3) == 0) bus.RESM = ~bus.RESM;
      bus.AddrSM    = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(100, 127)) : AW'($urandom_range(0, 99));
      bus.FrameDone = ($urandom_range(0, 11) == 0);
      tick();
    end
    idle_inputs();
    repeat (3) tick();

    // Asynchronous reset in the middle of a pending commit during a burst.
    bus.RESM = 1; bus.AddrSM = 7'd3; bus.FrameDone = 1;
    tick();
    bus.FrameDone = 0;
    tick();
    chk("t6_pend", 32'(bus.SwapPending), 32'd1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("t6_async");
    tick();
    idle_inputs();
    rst = 1'b0;
    tick();
    chk("t6_clean_idle", 32'(bus.SwapPending), 32'd0);
    bus.FrameDone = 1;
    tick();
    bus.FrameDone = 0;
    repeat (2) tick();
    chk("t6_RdBank", 32'(bus.RdBank), 32'd1);
    chk("t6_WrBank", 32'(bus.WrBank), 32'd2);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
